// File: rtl/store_buffer.sv
// MEM-stage store formatter plus a small write FIFO drained to Data Memory.
// Define STBUF_LD_CONFLICT_EN to build the word-granular load/store conflict detect.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid_i,
    input  logic [2:0]       st_funct3_i,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    output logic             st_ready_o,
    output logic             misalign_o,
    input  logic             fence_i,
    output logic             fence_busy_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_ready_i,
    output logic [CNT_W-1:0] count_o,
    input  logic             ld_valid_i,
    input  logic [31:0]      ld_addr_i,
    output logic             ld_conflict_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {StRun, StFence} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [29:0]      ent_addr_q [DEPTH];
    logic [29:0]      ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [3:0]       ent_be_q [DEPTH];
    logic [3:0]       ent_be_d [DEPTH];

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        fmt_bad;
    logic        push, pop;

    always_comb begin
        fmt_wdata = st_data_i;
        fmt_be    = 4'b0000;
        fmt_bad   = 1'b0;
        case (st_funct3_i)
            3'b000: begin
                fmt_wdata = {4{st_data_i[7:0]}};
                fmt_be    = 4'b0001 << st_addr_i[1:0];
            end
            3'b001: begin
                fmt_wdata = {2{st_data_i[15:0]}};
                fmt_be    = st_addr_i[1] ? 4'b1100 : 4'b0011;
                fmt_bad   = st_addr_i[0];
            end
            3'b010: begin
                fmt_be  = 4'b1111;
                fmt_bad = |st_addr_i[1:0];
            end
            default: fmt_bad = 1'b1;
        endcase
    end

    // Misaligned requests are dropped here, never reaching the queue or st_ready_o.
    assign misalign_o   = st_valid_i & fmt_bad;
    assign st_ready_o   = (count_q < CNT_W'(DEPTH)) && (state_q == StRun);
    assign push         = st_valid_i & st_ready_o & ~fmt_bad;
    assign mem_we_o     = (count_q != '0);
    assign pop          = mem_we_o & mem_ready_i;
    assign fence_busy_o = (state_q == StFence);
    assign count_o      = count_q;

    assign mem_addr_o  = mem_we_o ? {ent_addr_q[head_q], 2'b00} : 32'h0;
    assign mem_wdata_o = mem_we_o ? ent_data_q[head_q] : 32'h0;
    assign mem_be_o    = mem_we_o ? ent_be_q[head_q] : 4'b0000;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_be_d   = ent_be_q;
        if (push) begin
            tail_d             = tail_q + PTR_W'(1);
            ent_addr_d[tail_q] = st_addr_i[31:2];
            ent_data_d[tail_q] = fmt_wdata;
            ent_be_d[tail_q]   = fmt_be;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (fence_i) state_d = StFence;
            StFence: if ((count_q == '0) && !push) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_be_q   <= ent_be_d;
    end

`ifdef STBUF_LD_CONFLICT_EN
    logic [PTR_W-1:0] ld_off;
    logic             unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr_i[1:0];

    always_comb begin
        ld_conflict_o = 1'b0;
        ld_off        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ld_off = PTR_W'(i) - head_q;
            if ((CNT_W'(ld_off) < count_q) && (ent_addr_q[i] == ld_addr_i[31:2])) begin
                ld_conflict_o = ld_valid_i;
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld     = ld_valid_i ^ (^ld_addr_i);
    assign ld_conflict_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             st_valid;
    logic [2:0]       st_funct3;
    logic [31:0]      st_addr, st_data;
    logic             st_ready, misalign;
    logic             fence, fence_busy;
    logic             mem_we;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ready;
    logic [CNT_W-1:0] count;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_conflict;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    bit   mfence;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid_i   (st_valid),
        .st_funct3_i  (st_funct3),
        .st_addr_i    (st_addr),
        .st_data_i    (st_data),
        .st_ready_o   (st_ready),
        .misalign_o   (misalign),
        .fence_i      (fence),
        .fence_busy_o (fence_busy),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_ready_i  (mem_ready),
        .count_o      (count),
        .ld_valid_i   (ld_valid),
        .ld_addr_i    (ld_addr),
        .ld_conflict_o(ld_conflict)
    );

    // Reference formatting from the store rules; returns 1 when the request is legal.
    function automatic bit fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] wd, output logic [3:0] be);
        int off;
        off = int'(a % 4);
        wd  = 32'h0;
        be  = 4'h0;
        case (f3)
            3'd0: begin
                wd = 32'(d[7:0]) * 32'h0101_0101;
                be = 4'(1 << off);
                return 1'b1;
            end
            3'd1: begin
                wd = 32'(d[15:0]) * 32'h0001_0001;
                be = (off >= 2) ? 4'hC : 4'h3;
                return (off % 2) == 0;
            end
            3'd2: begin
                wd = d;
                be = 4'hF;
                return off == 0;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_conflict();
`ifdef STBUF_LD_CONFLICT_EN
        if (!ld_valid) return 1'b0;
        foreach (mq[k]) begin
            if (mq[k].addr[31:2] == ld_addr[31:2]) return 1'b1;
        end
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle();
        st_valid  = 1'b0;
        st_funct3 = 3'd2;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        fence     = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = 32'h0;
    endtask

    task automatic drive_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    // One clock: model evaluates with current inputs, then both advance to the next negedge.
    task automatic tick();
        ent_t        e;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          ok, push, pop;
        int          sz;
        sz   = mq.size();
        ok   = fmt(st_funct3, st_addr, st_data, wd, be);
        push = st_valid && ok && (sz < DEPTH) && !mfence;
        pop  = (sz > 0) && mem_ready;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.addr  = {st_addr[31:2], 2'b00};
            e.wdata = wd;
            e.be    = be;
            mq.push_back(e);
        end
        if (!mfence && fence) mfence = 1'b1;
        else if (mfence && sz == 0 && !push) mfence = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({count, mem_we, fence_busy, ld_conflict} !== 6'b0)
            $display("FAIL reset_ctrl: count/we/busy/conflict=%b expected 000000",
                     {count, mem_we, fence_busy, ld_conflict});
        else n_pass++;
        n_chk++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'h0)
            $display("FAIL reset_head: addr=%h wdata=%h be=%b expected zeros",
                     mem_addr, mem_wdata, mem_be);
        else n_pass++;
        rst_n = 1'b1;
        mq.delete();
        mfence = 1'b0;
        #1;
        n_chk++;
        if (st_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", st_ready);
        else n_pass++;
    endtask

    task automatic test_sb();
        drive_st(3'b000, 32'h0000_1003, 32'h0000_00A5);
        #1;
        n_chk++;
        if ({misalign, st_ready} !== 2'b01)
            $display("FAIL sb_accept: misalign/ready=%b expected 01", {misalign, st_ready});
        else n_pass++;
        tick();
        idle();
        n_chk++;
        if ({mem_we, count} !== {1'b1, 3'd1})
            $display("FAIL sb_latency: we=%b count=%0d expected we=1 count=1", mem_we, count);
        else n_pass++;
        n_chk++;
        if ({mem_addr, mem_wdata, mem_be} !== {32'h0000_1000, 32'hA5A5_A5A5, 4'b1000})
            $display("FAIL sb_format: addr=%h wdata=%h be=%b expected 00001000 a5a5a5a5 1000",
                     mem_addr, mem_wdata, mem_be);
        else n_pass++;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if ({mem_we, count} !== 4'b0)
            $display("FAIL sb_drain: we=%b count=%0d expected 0 0", mem_we, count);
        else n_pass++;
    endtask

    task automatic test_sh_misalign();
        drive_st(3'b001, 32'h0000_2002, 32'h1234_BEEF);
        tick();
        idle();
        n_chk++;
        if ({mem_be, mem_wdata, count} !== {4'b1100, 32'hBEEF_BEEF, 3'd1})
            $display("FAIL sh_format: be=%b wdata=%h count=%0d expected 1100 beefbeef 1",
                     mem_be, mem_wdata, count);
        else n_pass++;
        drive_st(3'b001, 32'h0000_2001, 32'h1234_BEEF);
        #1;
        n_chk++;
        if (misalign !== 1'b1) $display("FAIL sh_misalign: got %b expected 1", misalign);
        else n_pass++;
        tick();
        idle();
        n_chk++;
        if (count !== 3'd1) $display("FAIL sh_not_queued: count=%0d expected 1", count);
        else n_pass++;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] exp_a [4];
        exp_a = '{32'h104, 32'h108, 32'h10C, 32'h200};
        for (int i = 0; i < 4; i++) begin
            drive_st(3'b010, 32'h100 + 32'(4 * i), $urandom);
            tick();
        end
        idle();
        n_chk++;
        if ({count, st_ready} !== {3'd4, 1'b0})
            $display("FAIL full_state: count=%0d ready=%b expected 4 0", count, st_ready);
        else n_pass++;
        drive_st(3'b010, 32'h200, 32'hCAFE_0200);
        tick();
        n_chk++;
        if (count !== 3'd4) $display("FAIL full_blocked: count=%0d expected 4", count);
        else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++;
        if (st_ready !== 1'b0) $display("FAIL full_pop_push: ready=%b expected 0", st_ready);
        else n_pass++;
        tick();
        n_chk++;
        if ({count, mem_addr} !== {3'd3, 32'h104})
            $display("FAIL full_pop_only: count=%0d addr=%h expected 3 00000104", count, mem_addr);
        else n_pass++;
        mem_ready = 1'b0;
        #1;
        n_chk++;
        if (st_ready !== 1'b1) $display("FAIL full_reopen: ready=%b expected 1", st_ready);
        else n_pass++;
        tick();
        idle();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({mem_we, mem_addr} !== {1'b1, exp_a[i]})
                $display("FAIL full_order%0d: we=%b addr=%h expected 1 %h", i, mem_we, mem_addr,
                         exp_a[i]);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b0;
        n_chk++;
        if (count !== 3'd0) $display("FAIL full_empty: count=%0d expected 0", count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_st(3'b010, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i));
            tick();
            n_chk++;
            if ({count, mem_addr, mem_wdata} !== {3'd1, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i)})
                $display("FAIL stream%0d: count=%0d addr=%h wdata=%h expected 1 %h %h", i, count,
                         mem_addr, mem_wdata, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i));
            else n_pass++;
        end
        idle();
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (count !== 3'd0) $display("FAIL stream_end: count=%0d expected 0", count);
        else n_pass++;
    endtask

    task automatic test_fence();
        int busy;
        for (int i = 0; i < 3; i++) begin
            drive_st(3'b000, 32'h700 + 32'(i), 32'(i));
            tick();
        end
        idle();
        fence     = 1'b1;
        mem_ready = 1'b1;
        tick();
        fence = 1'b0;
        busy  = 0;
        for (int i = 0; i < 10; i++) begin
            if (fence_busy !== 1'b1) break;
            busy++;
            n_chk++;
            if (st_ready !== 1'b0) $display("FAIL fence_ready: ready=%b expected 0", st_ready);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (busy != 3) $display("FAIL fence_len: busy cycles=%0d expected 3", busy);
        else n_pass++;
        n_chk++;
        if ({count, st_ready} !== {3'd0, 1'b1})
            $display("FAIL fence_done: count=%0d ready=%b expected 0 1", count, st_ready);
        else n_pass++;
        fence = 1'b1;
        tick();
        fence = 1'b0;
        n_chk++;
        if (fence_busy !== 1'b1) $display("FAIL fence_empty1: busy=%b expected 1", fence_busy);
        else n_pass++;
        tick();
        mem_ready = 1'b0;
        n_chk++;
        if (fence_busy !== 1'b0) $display("FAIL fence_empty2: busy=%b expected 0", fence_busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] wd;
        logic [3:0]  be;
        bit          ok;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel       = int'($urandom_range(0, 3));
            st_valid  = ($urandom_range(0, 3) != 0);
            st_funct3 = (sel == 3) ? 3'($urandom_range(3, 7)) : 3'(sel);
            st_addr   = 32'h4000 + 32'($urandom_range(0, 63));
            st_data   = $urandom;
            mem_ready = ($urandom_range(0, 2) != 0);
            fence     = ($urandom_range(0, 15) == 0);
            ld_valid  = $urandom_range(0, 1) != 0;
            ld_addr   = 32'h4000 + 32'($urandom_range(0, 63));
            if (mq.size() > 0 && $urandom_range(0, 1) != 0)
                ld_addr = {mq[$urandom_range(0, mq.size() - 1)].addr[31:2], 2'($urandom)};
            ok = fmt(st_funct3, st_addr, st_data, wd, be);
            #1;
            n_chk++;
            if ({misalign, st_ready, ld_conflict} !==
                {st_valid && !ok, (mq.size() < DEPTH) && !mfence, exp_conflict()})
                $display("FAIL rnd_comb%0d: misalign/ready/conflict=%b%b%b expected %b%b%b", n,
                         misalign, st_ready, ld_conflict, st_valid && !ok,
                         (mq.size() < DEPTH) && !mfence, exp_conflict());
            else n_pass++;
            tick();
            n_chk++;
            if (mq.size() == 0) begin
                if ({count, mem_we, fence_busy} !== {3'd0, 1'b0, mfence})
                    $display("FAIL rnd_state%0d: count=%0d we=%b busy=%b expected 0 0 %b", n,
                             count, mem_we, fence_busy, mfence);
                else n_pass++;
            end else begin
                if ({count, mem_we, fence_busy, mem_addr, mem_wdata, mem_be} !==
                    {3'(mq.size()), 1'b1, mfence, mq[0].addr, mq[0].wdata, mq[0].be})
                    $display("FAIL rnd_state%0d: count=%0d busy=%b head=%h/%h/%b expected %0d %b %h/%h/%b",
                             n, count, fence_busy, mem_addr, mem_wdata, mem_be, mq.size(), mfence,
                             mq[0].addr, mq[0].wdata, mq[0].be);
                else n_pass++;
            end
        end
        idle();
        mem_ready = 1'b1;
        repeat (8) tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_st(3'b010, 32'h0000_3000, 32'h1111_2222);
        tick();
        idle();
`ifdef STBUF_LD_CONFLICT_EN
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3002;
        #1;
        n_chk++;
        if (ld_conflict !== 1'b1) $display("FAIL ld_hit: got %b expected 1", ld_conflict);
        else n_pass++;
        ld_addr = 32'h0000_3004;
        #1;
        n_chk++;
        if (ld_conflict !== 1'b0) $display("FAIL ld_miss: got %b expected 0", ld_conflict);
        else n_pass++;
        ld_addr = 32'h0000_3002;
`endif
        drive_st(3'b010, 32'h0000_3008, 32'h3333_4444);
        tick();
        st_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({count, mem_we, ld_conflict} !== 5'b0)
            $display("FAIL reset_mid: count=%0d we=%b conflict=%b expected 0 0 0", count, mem_we,
                     ld_conflict);
        else n_pass++;
        mq.delete();
        mfence = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_misalign();
        test_full();
        test_back_to_back();
        test_fence();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- MEM-stage store path: the write-side counterpart of the load extender.
- Takes a store (funct3M, address, rs2 data) and checks alignment.
- Replicates data into byte lanes and builds a 4-bit byte-enable.
- Queues the formatted write in a small FIFO and drains it to Data Memory with a valid/ready handshake.
- Asserts a back-pressure signal when full, and supports a fence drain.

Parameters:
DEPTH, 4, number of buffer entries; power of 2, >= 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_valid_i  in  1  store request this cycle (MemWriteM)
st_funct3_i  in  3  store type: 000 sb, 001 sh, 010 sw
st_addr_i  in  32  byte address (ALUResultM)
st_data_i  in  32  store data (WriteDataM)
st_ready_o  out  1  buffer can accept a store; pipeline stalls when low with st_valid_i high
misalign_o  out  1  combinational: current request misaligned or illegal funct3
fence_i  in  1  one-cycle pulse requesting a full drain
fence_busy_o  out  1  high from the cycle after a fence pulse until the buffer is empty
mem_we_o  out  1  head entry valid toward Data Memory
mem_addr_o  out  32  word-aligned address of the head entry (bits [1:0]=00)
mem_wdata_o  out  32  lane-replicated write data of the head entry
mem_be_o  out  4  byte enables of the head entry
mem_ready_i  in  1  Data Memory accepts the head this cycle
count_o  out  CNT_W  registered occupancy
ld_valid_i  in  1  load in MEM stage
ld_addr_i  in  32  load byte address
ld_conflict_o  out  1  load overlaps a pending store (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count go to 0; state goes to RUN.
  - mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, fence_busy_o=0, count_o=0, ld_conflict_o=0.
  - Entries pending when reset asserts are discarded.
- Formatting and misalignment:
  - sb: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: wdata={2{data[15:0]}}, be=addr[1]?4'b1100:4'b0011; misaligned if addr[0]=1.
  - sw: wdata=data, be=4'b1111; misaligned if addr[1:0]!=00.
  - Any other funct3 is illegal.
- misalign_o = st_valid_i & (misaligned | illegal). A misaligned or illegal request is never enqueued and does not affect st_ready_o.
- Push: st_valid_i & st_ready_o & ~misalign_o. The entry is written at the tail; the stored address is st_addr_i with bits [1:0] cleared.
- Pop: mem_we_o & mem_ready_i; head advances.
- mem_we_o = (count != 0). Head fields are driven from the head entry.
- There is no empty bypass: a pushed entry first appears at the memory port the cycle after the push, so latency is 1 cycle.
- A simultaneous push and pop leaves count unchanged. This is legal at any occupancy with st_ready_o high.
- st_ready_o = (count < DEPTH) & (state == RUN). When full, st_ready_o=0 even if a pop happens that cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM RUN/FENCE:
  - RUN -> FENCE on fence_i.
  - FENCE -> RUN when count==0 and no push in that cycle.
  - In FENCE, st_ready_o=0 and fence_busy_o=1.
  - A fence_i arriving with an already-empty buffer gives one FENCE cycle, then RUN.
  - fence_i is ignored while in FENCE.
- mem_ready_i while mem_we_o=0 is ignored.

Optional Feature:
- Macro STBUF_LD_CONFLICT_EN.
- Defined: ld_conflict_o = ld_valid_i & OR over valid entries of (entry.addr[31:2]==ld_addr_i[31:2]). This is word-granular and combinational; the hazard unit stalls the load until the entry drains.
- Undefined: ld_conflict_o is tied 0 and no compare logic is built. Software or the pipeline must not issue loads that overlap pending stores.

Test Plan:
- sb, addr=0x1003, data=0x000000A5 -> next cycle mem_we_o=1, mem_addr_o=0x1000, mem_be_o=1000, mem_wdata_o=0xA5A5A5A5; mem_ready_i=1 -> count_o 1->0.
- sh at 0x2002, data=0x1234BEEF -> be=1100, wdata=0xBEEFBEEF; sh at 0x2001 -> misalign_o=1, count_o unchanged.
- mem_ready_i=0, 4 sw pushes (DEPTH=4) -> count_o=4, st_ready_o=0; a 5th request stays blocked; one pop plus push the same cycle is refused; the next cycle accepts it.
- mem_ready_i=1 continuously with a push every cycle for 10 cycles -> count_o stays at 1 and entries drain in order across pointer wrap.
- 3 pending entries, fence_i pulse, mem_ready_i=1 -> fence_busy_o high 3 cycles; st_ready_o=0 throughout; RUN restored after empty.
- STBUF_LD_CONFLICT_EN defined: pending sw at 0x3000, load at 0x3002 -> ld_conflict_o=1; load at 0x3004 -> 0; after reset mid-queue -> count_o=0, mem_we_o=0.
